// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the data-memory byte serialiser.
// Size codes, FSM states, RAM address width, byte-count helper.
package mem_ctrl_pkg;

  localparam int RAM_ADDR_W = 17;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  // Index of the final byte; reserved size acts as word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      MEM_SIZE_B: r = 2'd0;
      MEM_SIZE_H: r = 2'd1;
      default:    r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Load-data extender: sign/zero-extends byte or half, passes word.
// Ports: data (assembled bytes), size, sgn -> ext.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    case (size)
      MEM_SIZE_B: ext = {{24{sgn & data[7]}}, data[7:0]};
      MEM_SIZE_H: ext = {{16{sgn & data[15]}}, data[15:0]};
      default:    ext = data;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage responder: serialises load/store into 8-bit RAM accesses.
// Ports: req_* in, req_ready/rsp_*/stall_o out, ram_* to byte RAM.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              stall_o,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  last;
  logic        we_q;
  logic        sgn_q;
  logic [1:0]  size_q;
  logic [23:0] wdata_q;
  logic [31:0] rbuf;
  logic [31:0] rbuf_next;
  logic [1:0]  sel;
  logic [31:0] ext;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  assign stall_o = req_valid && !rsp_valid;

  // RAM data lags its address by one cycle: in ACCESS we capture
  // the previous byte, in WAIT the final one.
  assign sel = (state == WAIT) ? idx : idx - 2'd1;

  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[sel*8 +: 8] = ram_rdata;
  end

  mem_load_ext u_ext (
    .data (rbuf_next),
    .size (size_q),
    .sgn  (sgn_q),
    .ext  (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      last      <= '0;
      we_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= '0;
      wdata_q   <= '0;
      rbuf      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ACCESS;
            idx       <= '0;
            last      <= last_idx(req_size);
            we_q      <= req_we;
            sgn_q     <= req_signed;
            size_q    <= req_size;
            wdata_q   <= req_wdata[31:8];
            rbuf      <= '0;
            req_ready <= 1'b0;
            ram_addr  <= req_addr[ADDR_W-1:0];
            ram_we    <= req_we;
            ram_wdata <= req_wdata[7:0];
          end
        end
        ACCESS: begin
          if (!we_q && idx != 2'd0) rbuf <= rbuf_next;
          if (idx == last) begin
            ram_we <= 1'b0;
            if (we_q) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= WAIT;
            end
          end else begin
            idx       <= idx + 2'd1;
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_wdata <= wdata_q[7:0];
            wdata_q   <= {8'h00, wdata_q[23:8]};
          end
        end
        WAIT: begin
          rbuf      <= rbuf_next;
          rsp_valid <= 1'b1;
          rsp_rdata <= ext;
          state     <= DONE;
        end
        DONE: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          idx       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural byte RAM.
// Prints CHECKS/ERRORS summary.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        stall_o;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:131071];
  logic [16:0] wa [$];
  logic [7:0]  wd [$];

  mem_ctrl #(.ADDR_W(17), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .stall_o    (stall_o),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wa.push_back(ram_addr);
      wd.push_back(ram_wdata);
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one request and wait for its response; called #1 after an edge.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic sgn,
                        input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat);
    int guard;
    logic stall_ok;
    req_we = we;
    req_addr = addr;
    req_size = size;
    req_signed = sgn;
    req_wdata = wdata;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
    lat = 1;
    stall_ok = 1'b1;
    while (!rsp_valid && lat < 20) begin
      if (!stall_o) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) chk("rsp_timeout", 32'(lat), 32'd0);
    chk("stall_busy", {31'd0, stall_ok}, 32'd1);
    chk("stall_rsp", {31'd0, stall_o}, 32'd0);
    rdata = rsp_rdata;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    int n0;

    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ram", {6'd0, ram_addr, ram_we, ram_wdata}, 32'd0);

    // Reset during byte 2 of a word store.
    req_we = 1'b1; req_addr = 32'h200; req_size = 2'b10;
    req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_addr", {15'd0, ram_addr}, 32'h202);
    chk("mid_we", {31'd0, ram_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, ram_we}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_addr", {15'd0, ram_addr}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready2", {31'd0, req_ready}, 32'd1);
    chk("arst_b1", {24'd0, mem[17'h201]}, 32'h33);
    chk("arst_b2", {24'd0, mem[17'h202]}, 32'h00);
    chk("arst_b3", {24'd0, mem[17'h203]}, 32'h00);

    // Word store.
    n0 = wa.size();
    do_req(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, rd, lat);
    chk("sw_lat", 32'(lat), 32'd5);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_nwr", 32'(wa.size() - n0), 32'd4);
    if (wa.size() - n0 == 4) begin
      chk("sw_w0", {7'd0, wa[n0], wd[n0]}, {7'd0, 17'h100, 8'hEF});
      chk("sw_w1", {7'd0, wa[n0+1], wd[n0+1]}, {7'd0, 17'h101, 8'hBE});
      chk("sw_w2", {7'd0, wa[n0+2], wd[n0+2]}, {7'd0, 17'h102, 8'hAD});
      chk("sw_w3", {7'd0, wa[n0+3], wd[n0+3]}, {7'd0, 17'h103, 8'hDE});
    end

    // Loads.
    n0 = wa.size();
    do_req(1'b0, 32'h100, 2'b10, 1'b0, 32'hFFFFFFFF, rd, lat);
    chk("lw_lat", 32'(lat), 32'd6);
    chk("lw_data", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, rd, lat);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_data", rd, 32'hFFFFFFDE);
    do_req(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, rd, lat);
    chk("lbu_data", rd, 32'h000000DE);
    do_req(1'b0, 32'h102, 2'b01, 1'b1, 32'h0, rd, lat);
    chk("lh_lat", 32'(lat), 32'd4);
    chk("lh_data", rd, 32'hFFFFDEAD);
    do_req(1'b0, 32'h100, 2'b01, 1'b0, 32'h0, rd, lat);
    chk("lhu_data", rd, 32'h0000BEEF);
    do_req(1'b0, 32'h100, 2'b11, 1'b1, 32'h0, rd, lat);
    chk("lrsv_lat", 32'(lat), 32'd6);
    chk("lrsv_data", rd, 32'hDEADBEEF);
    chk("ld_nowr", 32'(wa.size() - n0), 32'd0);

    // Half store across the address wrap.
    n0 = wa.size();
    do_req(1'b1, 32'h1FFFF, 2'b01, 1'b0, 32'hAAAA1234, rd, lat);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_nwr", 32'(wa.size() - n0), 32'd2);
    if (wa.size() - n0 == 2) begin
      chk("sh_w0", {7'd0, wa[n0], wd[n0]}, {7'd0, 17'h1FFFF, 8'h34});
      chk("sh_w1", {7'd0, wa[n0+1], wd[n0+1]}, {7'd0, 17'h00000, 8'h12});
    end
    do_req(1'b0, 32'h0003FFFF, 2'b01, 1'b1, 32'h0, rd, lat);
    chk("lh_wrap", rd, 32'h00001234);

    // Held request: one idle cycle between accesses.
    n0 = wa.size();
    req_we = 1'b1; req_addr = 32'h300; req_size = 2'b00;
    req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_rdy0", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_acc1", {31'd0, ram_we}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_done1", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_gap", {29'd0, req_ready, ram_we, rsp_valid}, 32'b100);
    @(posedge clk); #1;
    chk("b2b_acc2", {30'd0, req_ready, ram_we}, 32'b01);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done2", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_nwr", 32'(wa.size() - n0), 32'd2);
    chk("b2b_mem", {24'd0, mem[17'h300]}, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
